// File: rtl/accum_table_wr_ctrl.sv
// Write-side address sequencer for the accumulator table: follows the skewed output
// wavefront of the systolic array and drives per-column write strobes and addresses.
module accum_table_wr_ctrl #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_ROWS = 16,
    parameter int unsigned SYS_ARR_COLS = 16,
    localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int unsigned AW = $clog2(NUM_ACCUM_ROWS),
    localparam int unsigned NUM_STEPS = SYS_ARR_ROWS + SYS_ARR_COLS - 1,
    localparam int unsigned RIW = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS),
    localparam int unsigned CIW = $clog2(MAX_OUT_COLS / SYS_ARR_COLS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [RIW-1:0]             submat_row_idx,
    input  logic [CIW-1:0]             submat_col_idx,
    input  logic                       accum_mode,
    input  logic                       out_valid,
    output logic [SYS_ARR_COLS-1:0]    wr_en,
    output logic [AW*SYS_ARR_COLS-1:0] wr_addr,
    output logic [SYS_ARR_COLS-1:0]    wr_accum,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SW = $clog2(NUM_STEPS + 1);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [RIW-1:0] row_idx_q, row_idx_d;
    logic [CIW-1:0] col_idx_q, col_idx_d;
    logic           accum_q, accum_d;
    logic           done_q, done_d;

    logic [AW-1:0]  base;
    logic [SW-1:0]  sub_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            step_q    <= '0;
            row_idx_q <= '0;
            col_idx_q <= '0;
            accum_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            accum_q   <= accum_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        accum_d   = accum_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_idx_d = submat_row_idx;
                    col_idx_d = submat_col_idx;
                    accum_d   = accum_mode;
                    step_d    = '0;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                // A stalled cycle holds the step so no wavefront step is lost.
                if (out_valid) begin
                    if (step_q == SW'(NUM_STEPS - 1)) begin
                        step_d  = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Same tile base as the read path: column-tile block first, then row tile.
    assign base = AW'(col_idx_q) * AW'(MAX_OUT_ROWS) + AW'(row_idx_q) * AW'(SYS_ARR_ROWS);

    // Column c sees array row (step - c) of the diagonal wavefront.
    always_comb begin
        wr_en    = '0;
        wr_addr  = '0;
        wr_accum = '0;
        sub_row  = '0;
        for (int c = 0; c < SYS_ARR_COLS; c++) begin
            sub_row = step_q - SW'(c);
            if (state_q == StWrite && step_q >= SW'(c) && sub_row < SW'(SYS_ARR_ROWS)) begin
                wr_addr[c*AW +: AW] = base + AW'(sub_row);
                wr_en[c]            = out_valid;
                wr_accum[c]         = accum_q & out_valid;
            end
        end
    end

    assign busy = (state_q == StWrite);
    assign done = done_q;

endmodule
